pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the fetch stage, replacing the fixed add-4 incrementer. It holds the PC register, steps it by a configurable increment, and selects the next PC from exception, jump and branch redirects. It handshakes with instruction fetch, supports halt/resume, and flags increment wrap-around and misaligned targets. It sits between the branch/jump resolution logic and the instruction memory address port.

Parameters:
WIDTH, 32, PC and target width in bits
INC, 4, byte increment per sequential step
ALIGN_BITS, 2, number of low PC bits that must be zero
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, PC value loaded on exception

Ports:
Clock  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
FetchReady  in  1  fetch accepts the current PC this cycle
Stall  in  1  hold the PC (pipeline stall)
Branch  in  1  take BranchTarget
BranchTarget  in  WIDTH  branch destination
Jump  in  1  take JumpTarget
JumpTarget  in  WIDTH  jump destination
Exception  in  1  redirect to EXC_VECTOR
Halt  in  1  request halt
Resume  in  1  leave halt
Pc  out  WIDTH  current PC (registered)
PcPlus  out  WIDTH  Pc + INC modulo 2^WIDTH (combinational, link value)
PcValid  out  1  Pc is a valid fetch address
Overflow  out  1  sticky: a sequential increment has wrapped
Misaligned  out  1  one-cycle pulse: the accepted target had nonzero low ALIGN_BITS

Behaviour:
- Reset (nReset low, asynchronous): Pc=RESET_VECTOR, state=BOOT, PcValid=0, Overflow=0, Misaligned=0.
- States: BOOT, RUN, HALTED. PcValid=1 only in RUN (registered).
- BOOT -> RUN on the first clock edge after reset release. Pc holds.
- RUN: next-PC priority is Exception > Jump > Branch > Stall > step.
  - Exception: Pc<=EXC_VECTOR.
  - Jump: Pc<=JumpTarget with the low ALIGN_BITS forced to 0.
  - Branch: Pc<=BranchTarget with the low ALIGN_BITS forced to 0.
  - Stall: hold.
  - Step: Pc<=Pc+INC only when FetchReady=1; otherwise hold.
  - Redirects take effect regardless of FetchReady or Stall (flush semantics).
- Step arithmetic is WIDTH-bit. On a carry out of the step, Pc wraps modulo 2^WIDTH and Overflow is set. Overflow is sticky until reset. PcPlus wrap does not set Overflow.
- Misaligned: registered, high in the cycle after a Jump/Branch is taken whose raw target had any nonzero low ALIGN_BITS. It is not set when Exception overrides the redirect.
- RUN -> HALTED on Halt=1 when Exception=0. The Pc update that edge follows the normal priority (Jump/Branch still taken), then Pc holds and PcValid=0.
- HALTED:
  - Exception: Pc<=EXC_VECTOR, -> RUN.
  - Resume=1: -> RUN with Pc unchanged.
  - Jump/Branch/Stall/FetchReady are ignored.
  - Halt and Resume both high: Resume wins.
- RUN with Resume only: no effect.
- Reset asserted mid-operation overrides everything immediately. BOOT is re-entered.
- INC must be a multiple of 2^ALIGN_BITS (elaboration-time check). RESET_VECTOR and EXC_VECTOR must be aligned (elaboration-time check).

Test Plan:
1. Release reset, FetchReady=1 for 4 cycles -> PcValid=0 in BOOT cycle, then Pc=0,4,8,12. PcPlus=Pc+4 each cycle.
2. RUN at Pc=0x100, FetchReady=0 two cycles then 1; Stall=1 one cycle -> Pc holds 0x100 while FetchReady=0 or Stall=1, then 0x104.
3. Exception, Jump=0x2000 and Branch=0x3000 in the same cycle -> Pc=0x80000180. Jump=0x2000 with Branch=0x3000 -> Pc=0x2000. Stall=1 with Branch=0x3000 -> Pc=0x3000.
4. Jump with JumpTarget=0x0000_1003 -> Pc=0x1000, Misaligned=1 for exactly one cycle.
5. Pc=0xFFFF_FFFC, FetchReady=1 -> Pc=0x0, Overflow=1 and stays 1 through further steps until nReset pulse clears it.
6. Halt at Pc=0x40 -> Pc=0x44, then holds with PcValid=0 while Branch pulses. Resume -> PcValid=1 and stepping continues from 0x44. A second halt followed by Exception -> Pc=0x80000180 and state RUN.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with configurable step and exception/jump/branch redirects.
// Also handles halt/resume, flags a wrapped sequential step, and flags misaligned redirect targets.
module pc_sequencer #(
   parameter int               WIDTH        = 32,
   parameter int               INC          = 4,
   parameter int               ALIGN_BITS   = 2,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             FetchReady,
   input  logic             Stall,
   input  logic             Branch,
   input  logic [WIDTH-1:0] BranchTarget,
   input  logic             Jump,
   input  logic [WIDTH-1:0] JumpTarget,
   input  logic             Exception,
   input  logic             Halt,
   input  logic             Resume,
   output logic [WIDTH-1:0] Pc,
   output logic [WIDTH-1:0] PcPlus,
   output logic             PcValid,
   output logic             Overflow,
   output logic             Misaligned
);

   localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
   localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;

   if ((INC % (2 ** ALIGN_BITS)) != 0) begin : g_inc_check
      $error("pc_sequencer: INC must be a multiple of 2**ALIGN_BITS");
   end
   if (((RESET_VECTOR & ~ALIGN_MASK) != '0) || ((EXC_VECTOR & ~ALIGN_MASK) != '0)) begin : g_vec_check
      $error("pc_sequencer: RESET_VECTOR and EXC_VECTOR must be aligned");
   end

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALTED} state_t;

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_pc, w_pc_next;
   logic             r_pc_valid, r_overflow, r_misaligned;
   logic             w_overflow_set, w_misaligned_set;
   logic [WIDTH:0]   w_step_sum;

   // The extra top bit of the sum is the carry that marks a wrapped step.
   assign w_step_sum = {1'b0, r_pc} + {1'b0, INC_W};
   assign PcPlus     = w_step_sum[WIDTH-1:0];

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      w_state_next     = r_state;
      w_pc_next        = r_pc;
      w_overflow_set   = 1'b0;
      w_misaligned_set = 1'b0;
      case (r_state)
         ST_BOOT: w_state_next = ST_RUN;
         ST_RUN: begin
            if (Exception) begin
               w_pc_next = EXC_VECTOR;
            end else if (Jump) begin
               w_pc_next        = JumpTarget & ALIGN_MASK;
               w_misaligned_set = |(JumpTarget & ~ALIGN_MASK);
            end else if (Branch) begin
               w_pc_next        = BranchTarget & ALIGN_MASK;
               w_misaligned_set = |(BranchTarget & ~ALIGN_MASK);
            end else if (!Stall && FetchReady) begin
               w_pc_next      = w_step_sum[WIDTH-1:0];
               w_overflow_set = w_step_sum[WIDTH];
            end
            if (Halt && !Exception) w_state_next = ST_HALTED;
         end
         ST_HALTED: begin
            // Only an exception or resume wakes the sequencer; redirects are dropped.
            if (Exception) begin
               w_pc_next    = EXC_VECTOR;
               w_state_next = ST_RUN;
            end else if (Resume) begin
               w_state_next = ST_RUN;
            end
         end
         default: w_state_next = ST_BOOT;
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_VECTOR;
         r_pc_valid   <= 1'b0;
         r_overflow   <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         r_state      <= w_state_next;
         r_pc         <= w_pc_next;
         r_pc_valid   <= (w_state_next == ST_RUN);
         r_overflow   <= r_overflow | w_overflow_set;
         r_misaligned <= w_misaligned_set;
      end
   end

   assign Pc         = r_pc;
   assign PcValid    = r_pc_valid;
   assign Overflow   = r_overflow;
   assign Misaligned = r_misaligned;

endmodule
